// File: rtl/exhaustive_vector_driver.sv
// Exhaustive stimulus/response stage: walks every input vector of a small
// combinational circuit, holds each for HOLD_CYCLES and grades the response.
module exhaustive_vector_driver #(
  parameter int                   N_IN        = 3,
  parameter int                   HOLD_CYCLES = 10,
  parameter logic [(1<<N_IN)-1:0] EXPECTED    = 8'hEA
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  output logic [N_IN-1:0]        OutVec,
  input  logic                   RespF,
  output logic                   Busy,
  output logic                   Done,
  output logic [N_IN:0]          ErrCount,
  output logic                   ErrFlag,
  output logic [N_IN-1:0]        FirstErrVec,
  output logic [(1<<N_IN)-1:0]   Observed
);

  localparam int NV = 1 << N_IN;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(NV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic [NV-1:0]     obs_q, obs_d;

  // NOTE: every _d gets its current value first so no path through the case
  // leaves a signal unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    err_d   = err_q;
    first_d = first_q;
    obs_d   = obs_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_DRIVE;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          first_d = '0;
          obs_d   = '0;
        end
      end

      ST_DRIVE: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          // Last edge of the window: the response has had HOLD_CYCLES-1 cycles to settle.
          obs_d[vec_q] = RespF;
          if (RespF != EXPECTED[vec_q]) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) first_d = vec_q;
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      obs_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      first_q <= first_d;
      obs_q   <= obs_d;
    end
  end

  assign OutVec      = vec_q;
  assign Busy        = (state_q == ST_DRIVE);
  assign Done        = (state_q == ST_DONE);
  assign ErrCount    = err_q;
  assign ErrFlag     = (err_q != '0);
  assign FirstErrVec = first_q;
  assign Observed    = obs_q;

endmodule

// File: tb/tb_exhaustive_vector_driver.sv
// Scoreboard bench: stimulus pushes expected run results, monitors pop and
// compare them when Done rises.
module tb_exhaustive_vector_driver;

  typedef struct {
    logic [31:0] err;
    logic [31:0] first;
    logic [31:0] obs;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start, Start2;
  logic [1:0] mode;

  logic [2:0] OutVec;
  logic       RespF, Busy, Done, ErrFlag;
  logic [3:0] ErrCount;
  logic [2:0] FirstErrVec;
  logic [7:0] Observed;

  logic [1:0] OutVec2;
  logic       RespF2, Busy2, Done2, ErrFlag2;
  logic [2:0] ErrCount2;
  logic [1:0] FirstErrVec2;
  logic [3:0] Observed2;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 Clk = ~Clk;

  exhaustive_vector_driver #(.N_IN(3), .HOLD_CYCLES(10), .EXPECTED(8'hEA)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OutVec(OutVec), .RespF(RespF),
    .Busy(Busy), .Done(Done), .ErrCount(ErrCount), .ErrFlag(ErrFlag),
    .FirstErrVec(FirstErrVec), .Observed(Observed)
  );

  exhaustive_vector_driver #(.N_IN(2), .HOLD_CYCLES(2), .EXPECTED(4'b0110)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start2), .OutVec(OutVec2), .RespF(RespF2),
    .Busy(Busy2), .Done(Done2), .ErrCount(ErrCount2), .ErrFlag(ErrFlag2),
    .FirstErrVec(FirstErrVec2), .Observed(Observed2)
  );

  // Circuit models: 0 = C|(A&B), 1 = stuck-at-0, 2 = C|(A&B) with vector 6 inverted.
  always_comb begin
    case (mode)
      2'd1:    RespF = 1'b0;
      2'd2:    RespF = (OutVec == 3'd6) ? 1'b0 : (OutVec[0] | (OutVec[2] & OutVec[1]));
      default: RespF = OutVec[0] | (OutVec[2] & OutVec[1]);
    endcase
  end
  assign RespF2 = OutVec2[1] ^ OutVec2[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 3-input instance.
  int  busy_cnt  = 0;
  bit  busy_prev = 0;
  bit  done_prev = 0;
  always @(negedge Clk) begin
    if (Busy) begin
      busy_cnt = busy_prev ? busy_cnt + 1 : 1;
      if ((busy_cnt - 1) % 10 == 0)
        check("outvec_step", 32'(OutVec), 32'((busy_cnt - 1) / 10));
    end
    if (Done && !done_prev) begin
      check("busy_cycles", 32'(busy_cnt), 32'd80);
      if (q1.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("err_count",  32'(ErrCount),    e.err);
        check("err_flag",   32'(ErrFlag),     32'(e.err != 0));
        check("first_err",  32'(FirstErrVec), e.first);
        check("observed",   32'(Observed),    e.obs);
      end
    end
    busy_prev = Busy;
    done_prev = Done;
  end

  // Monitor for the 2-input XOR instance.
  int  busy2_cnt  = 0;
  bit  busy2_prev = 0;
  bit  done2_prev = 0;
  always @(negedge Clk) begin
    if (Busy2) busy2_cnt = busy2_prev ? busy2_cnt + 1 : 1;
    if (Done2 && !done2_prev) begin
      check("busy2_cycles", 32'(busy2_cnt), 32'd8);
      if (q2.size() == 0) begin
        check("unexpected_done2", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check("err_count2", 32'(ErrCount2),    e.err);
        check("err_flag2",  32'(ErrFlag2),     32'(e.err != 0));
        check("first_err2", 32'(FirstErrVec2), e.first);
        check("observed2",  32'(Observed2),    e.obs);
      end
    end
    busy2_prev = Busy2;
    done2_prev = Done2;
  end

  task automatic launch(input bit push, input logic [31:0] err,
                        input logic [31:0] first, input logic [31:0] obs);
    exp_t e;
    e.err = err; e.first = first; e.obs = obs;
    if (push) q1.push_back(e);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!Done && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    check({name, "_timeout"}, 32'(Done), 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    int n;
    exp_t e2;
    Reset = 1'b1; Start = 1'b0; Start2 = 1'b0; mode = 2'd0;
    repeat (3) @(negedge Clk);

    check("rst_outvec",   32'(OutVec),      32'd0);
    check("rst_busy",     32'(Busy),        32'd0);
    check("rst_done",     32'(Done),        32'd0);
    check("rst_errcount", 32'(ErrCount),    32'd0);
    check("rst_errflag",  32'(ErrFlag),     32'd0);
    check("rst_first",    32'(FirstErrVec), 32'd0);
    check("rst_observed", 32'(Observed),    32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // Correct circuit; results must stay frozen while in DONE.
    mode = 2'd0;
    launch(1, 32'd0, 32'd0, 32'hEA);
    wait_done("run_good");
    repeat (20) @(negedge Clk);
    check("done_hold_done",     32'(Done),     32'd1);
    check("done_hold_busy",     32'(Busy),     32'd0);
    check("done_hold_outvec",   32'(OutVec),   32'd7);
    check("done_hold_observed", 32'(Observed), 32'hEA);

    // Stuck-at-0 output.
    mode = 2'd1;
    launch(1, 32'd5, 32'd1, 32'h00);
    wait_done("run_stuck0");

    // Vector 6 inverted.
    mode = 2'd2;
    launch(1, 32'd1, 32'd6, 32'hAA);
    wait_done("run_vec6");

    // Start during DRIVE must be ignored.
    mode = 2'd0;
    launch(1, 32'd0, 32'd0, 32'hEA);
    repeat (29) @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("restart_ignored_busy", 32'(Busy), 32'd1);
    wait_done("run_restart_ignored");

    // Start from DONE clears the previous results on the launch edge.
    mode = 2'd2;
    launch(1, 32'd1, 32'd6, 32'hAA);
    check("relaunch_observed", 32'(Observed), 32'd0);
    check("relaunch_errcount", 32'(ErrCount), 32'd0);
    check("relaunch_done",     32'(Done),     32'd0);
    check("relaunch_busy",     32'(Busy),     32'd1);
    check("relaunch_outvec",   32'(OutVec),   32'd0);
    wait_done("run_relaunch");

    // Asynchronous reset mid-run at vector 4 (stuck-at-0 so counters are nonzero).
    mode = 2'd1;
    launch(0, 32'd0, 32'd0, 32'd0);
    n = 0;
    while (OutVec != 3'd4 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("midrun_reached_vec4", 32'(OutVec), 32'd4);
    check("midrun_errs_present", 32'(ErrCount), 32'd2);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_outvec",   32'(OutVec),      32'd0);
    check("async_rst_busy",     32'(Busy),        32'd0);
    check("async_rst_done",     32'(Done),        32'd0);
    check("async_rst_errcount", 32'(ErrCount),    32'd0);
    check("async_rst_errflag",  32'(ErrFlag),     32'd0);
    check("async_rst_first",    32'(FirstErrVec), 32'd0);
    check("async_rst_observed", 32'(Observed),    32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    check("post_rst_idle_done", 32'(Done),   32'd0);
    check("post_rst_idle_busy", 32'(Busy),   32'd0);
    check("post_rst_outvec",    32'(OutVec), 32'd0);

    // Two-input XOR instance, HOLD_CYCLES=2.
    e2.err = 32'd0; e2.first = 32'd0; e2.obs = 32'h6;
    q2.push_back(e2);
    Start2 = 1'b1;
    @(negedge Clk);
    Start2 = 1'b0;
    n = 0;
    while (!Done2 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("run_xor_timeout", 32'(Done2), 32'd1);
    @(negedge Clk);

    check("scoreboard1_drained", 32'(q1.size()), 32'd0);
    check("scoreboard2_drained", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exhaustive_vector_driver.md
Name: exhaustive_vector_driver

Overview:
Clocked stimulus/response stage for small combinational circuits under test. It walks every input combination of an N_IN-input circuit in ascending binary order and holds each for a fixed number of cycles. It samples the circuit's single output at the end of each hold window, compares it against a parameterised truth table, and reports mismatch count, first failing vector and the full observed response. It sits directly upstream of the circuit under test, drives its inputs, and consumes its output.

Parameters:
N_IN, 3, number of circuit inputs (1..6); vector count NV = 2^N_IN.
HOLD_CYCLES, 10, cycles each vector is held (>=2).
EXPECTED, 8'hEA, NV-bit golden truth table; bit i = expected output for input vector i (default is F = C | (A & B)).

Ports:
Clk  in  1  rising-edge clock.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  one-cycle launch pulse; honoured in IDLE or DONE only.
OutVec  out  N_IN  drive to circuit inputs; MSB = InA, LSB = last input.
RespF  in  1  circuit output.
Busy  out  1  high while vectors are being applied.
Done  out  1  high from run completion until next Start or Reset.
ErrCount  out  N_IN+1  number of mismatching vectors in the last run (0..NV).
ErrFlag  out  1  ErrCount != 0.
FirstErrVec  out  N_IN  first mismatching vector index; 0 if none.
Observed  out  NV  captured response, bit i = RespF sampled for vector i.

Behaviour:
- Reset (any time, including mid-run): state IDLE; OutVec=0, Busy=0, Done=0, ErrCount=0, ErrFlag=0, FirstErrVec=0, Observed=0, hold counter=0. Reset takes effect immediately, not at the next edge.
- States: IDLE, DRIVE, DONE.
- IDLE/DONE + Start at edge k:
  - Go to DRIVE.
  - OutVec=0, hold counter=0, Busy=1, Done=0.
  - ErrCount=0, FirstErrVec=0, Observed=0.
- DRIVE, each edge: if hold counter < HOLD_CYCLES-1, increment it; OutVec is unchanged.
- DRIVE, edge where hold counter == HOLD_CYCLES-1 (sample edge):
  - Observed[OutVec] <= RespF.
  - If RespF != EXPECTED[OutVec]: ErrCount+1. If ErrCount was 0, FirstErrVec <= OutVec.
  - If OutVec == NV-1: go to DONE with Busy=0, Done=1, OutVec held at NV-1.
  - Otherwise: OutVec+1, hold counter=0.
- Timing:
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - RespF is sampled at the last edge of its window, so it has HOLD_CYCLES-1 cycles to settle.
  - Busy is high for exactly NV*HOLD_CYCLES cycles; Done rises on the same edge Busy falls.
- Start while in DRIVE is ignored; the run is not restarted.
- ErrFlag is combinational from ErrCount.
- ErrCount saturates naturally at NV; its width makes overflow impossible.
- OutVec wrap-around never occurs; the last vector ends the run.
- Start asserted on the same edge Reset deasserts is ignored. Reset dominates.
- DONE holds all results stable indefinitely.
- Start from DONE clears the results and begins a new run.

Test Plan:
- Correct circuit F=C|(A&B), EXPECTED=8'hEA, HOLD_CYCLES=10, Start pulse -> OutVec steps 0..7 every 10 cycles; Busy high 80 cycles; Done=1; ErrCount=0; ErrFlag=0; Observed=8'hEA; FirstErrVec=0.
- Stuck-at-0 RespF -> ErrCount=5, FirstErrVec=1, Observed=8'h00, ErrFlag=1.
- Circuit with vector 6 inverted (RespF=0 at 6) -> ErrCount=1, FirstErrVec=6, Observed=8'hAA.
- Start pulsed again at cycle 30 of a run -> ignored; run still ends after 80 cycles total with unchanged results. Then Start in DONE -> results cleared on that edge and a new 80-cycle run begins.
- Reset asserted mid-run at OutVec=4 -> all outputs 0 immediately; IDLE; no Done until a new Start.
- N_IN=2, HOLD_CYCLES=2, EXPECTED=4'b0110 with an XOR circuit -> Busy for 8 cycles; ErrCount=0; Observed=4'b0110.
